// File: rtl/arbitro_rr_merge_if.sv
// Handshake bundle between the four class FIFOs,
// the merge arbiter and the downstream FIFO.
interface arbitro_rr_merge_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
);
  logic [3:0]          empty;
  logic [4*DATA_W-1:0] fifo_in;
  logic                almost_full;
  logic [3:0]          pop;
  logic                push;
  logic [DATA_W-1:0]   data_out;
  logic [1:0]          grant;
  logic [4*CNT_W-1:0]  served;

  modport master (
    input  empty, fifo_in, almost_full,
    output pop, push, data_out, grant, served
  );

  modport slave (
    output empty, fifo_in, almost_full,
    input  pop, push, data_out, grant, served
  );
endinterface

// File: rtl/arbitro_rr_merge.sv
// Weighted round-robin merge of four class FIFOs
// into one downstream FIFO, registered output.
module arbitro_rr_merge #(
  parameter int DATA_W = 12,
  parameter int WEIGHT = 2,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  arbitro_rr_merge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [3:0] WMAX = 4'(WEIGHT);

  state_t             state_q, state_d;
  logic [1:0]         grant_q;
  logic [1:0]         rr_ptr_q;
  logic [3:0]         burst_q, burst_d;
  logic               push_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   served_q [4];

  logic [1:0]         sel;
  logic [1:0]         idx;
  logic               keep;
  logic               early;
  logic               avail;
  logic               do_pop;
  logic [DATA_W-1:0]  head;

  // Source selection: hold the grant while its burst lasts,
  // otherwise first non-empty source from rr_ptr onward.
  always_comb begin
    keep  = !bus.empty[grant_q] && (burst_q < WMAX);
    early = bus.empty[grant_q] && (burst_q < WMAX);
    avail = |(~bus.empty);
    sel   = grant_q;
    idx   = 2'd0;
    if (!keep) begin
      sel = rr_ptr_q;
      for (int k = 3; k >= 0; k--) begin
        idx = rr_ptr_q + 2'(k);
        if (!bus.empty[idx]) sel = idx;
      end
    end
    burst_d = keep ? burst_q + 4'd1 : 4'd1;
    head    = bus.fifo_in[int'(sel)*DATA_W +: DATA_W];
  end

  // Next state and pop enable; reset always kills the pop.
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.almost_full && avail) state_d = SERVE;
      end
      SERVE: begin
        do_pop = !bus.almost_full && avail;
        if (bus.almost_full) state_d = STALL;
        else if (!avail)     state_d = IDLE;
      end
      STALL: begin
        if (!bus.almost_full) state_d = avail ? SERVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) do_pop = 1'b0;
  end

  assign bus.pop      = do_pop ? (4'b0001 << sel) : 4'b0000;
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign bus.grant    = grant_q;

  // Flatten the per-source counters onto the output bus.
  always_comb begin
    bus.served = '0;
    for (int i = 0; i < 4; i++)
      bus.served[i*CNT_W +: CNT_W] = served_q[i];
  end

  // State, output register, burst/pointer and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      push_q   <= 1'b0;
      data_q   <= '0;
      grant_q  <= 2'd0;
      burst_q  <= 4'd0;
      rr_ptr_q <= 2'd0;
      for (int i = 0; i < 4; i++) served_q[i] <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= do_pop;
      if (do_pop) begin
        data_q  <= head;
        grant_q <= sel;
        burst_q <= burst_d;
        if (burst_d == WMAX || early)
          rr_ptr_q <= sel + 2'd1;
        if (served_q[sel] != '1)
          served_q[sel] <= served_q[sel] + 1'b1;
      end
    end
  end

endmodule
